// File: rtl/pgen_core.sv
// Pulse-train generator: emits count pulses of period/high cycles with a direction flag and hold qualifier.
// Latency: a valid start sampled at one edge shows event_o/busy_o on the next; every output is registered.
module pgen_core #(
    parameter int CNT_W = 16,
    parameter int PER_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             dir_i,
    input  logic [CNT_W-1:0] count_i,
    input  logic [PER_W-1:0] period_i,
    input  logic [PER_W-1:0] high_i,
    output logic             event_o,
    output logic             up_down_o,
    output logic             hold_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [CNT_W-1:0] remaining_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [PER_W-1:0] r_phase;
    logic [PER_W-1:0] w_phase_nxt;
    logic [PER_W-1:0] r_period;
    logic [PER_W-1:0] r_high;
    logic [CNT_W-1:0] w_rem_nxt;
    logic             w_params_ok;
    logic             w_start_ok;
    logic             w_start_bad;
    logic             w_active_nxt;

    // high < period also guarantees period >= 2 once high is non-zero
    assign w_params_ok  = (count_i != '0) && (high_i != '0) && (high_i < period_i);
    assign w_start_ok   = (r_state == S_IDLE) && start_i && !abort_i && w_params_ok;
    assign w_start_bad  = (r_state == S_IDLE) && start_i && !abort_i && !w_params_ok;
    assign w_active_nxt = (w_next == S_HIGH) || (w_next == S_LOW);

    always_comb begin
        w_next      = r_state;
        w_phase_nxt = r_phase;
        w_rem_nxt   = remaining_o;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_next      = S_HIGH;
                    w_phase_nxt = high_i;
                    w_rem_nxt   = count_i;
                end
            end
            S_HIGH: begin
                if (abort_i) begin
                    w_next = S_IDLE;
                end else if (r_phase == PER_W'(1)) begin
                    w_next      = S_LOW;
                    w_phase_nxt = r_period - r_high;
                    if (remaining_o != '0) begin
                        w_rem_nxt = remaining_o - CNT_W'(1);
                    end
                end else begin
                    w_phase_nxt = r_phase - PER_W'(1);
                end
            end
            S_LOW: begin
                if (abort_i) begin
                    w_next = S_IDLE;
                end else if (r_phase == PER_W'(1)) begin
                    if (remaining_o != '0) begin
                        w_next      = S_HIGH;
                        w_phase_nxt = r_high;
                    end else begin
                        w_next = S_DONE;
                    end
                end else begin
                    w_phase_nxt = r_phase - PER_W'(1);
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_phase     <= '0;
            r_period    <= '0;
            r_high      <= '0;
            remaining_o <= '0;
            event_o     <= 1'b0;
            up_down_o   <= 1'b0;
            hold_o      <= 1'b1;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_phase     <= w_phase_nxt;
            remaining_o <= w_rem_nxt;
            if (w_start_ok) begin
                r_period  <= period_i;
                r_high    <= high_i;
                up_down_o <= dir_i;
            end
            // outputs follow the next state so they line up with it cycle for cycle
            event_o <= (w_next == S_HIGH);
            busy_o  <= w_active_nxt;
            hold_o  <= !w_active_nxt;
            done_o  <= (w_next == S_DONE);
            err_o   <= w_start_bad;
        end
    end

endmodule

// File: tb/tb_pgen_core.sv
// Bench for pgen_core: per-cycle expected outputs from a timeline model feed a queue checked by a monitor.
module tb_pgen_core;

    localparam int CW = 8;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic          abort_i;
    logic          dir_i;
    logic [CW-1:0] count_i;
    logic [PW-1:0] period_i;
    logic [PW-1:0] high_i;
    logic          event_o;
    logic          up_down_o;
    logic          hold_o;
    logic          busy_o;
    logic          done_o;
    logic          err_o;
    logic [CW-1:0] remaining_o;

    pgen_core #(.CNT_W(CW), .PER_W(PW)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .abort_i    (abort_i),
        .dir_i      (dir_i),
        .count_i    (count_i),
        .period_i   (period_i),
        .high_i     (high_i),
        .event_o    (event_o),
        .up_down_o  (up_down_o),
        .hold_o     (hold_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .remaining_o(remaining_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          ev;
        logic          ud;
        logic          hold;
        logic          busy;
        logic          done;
        logic          err;
        logic [CW-1:0] rem;
    } obs_t;

    localparam obs_t RST_OBS = '{ev: 1'b0, ud: 1'b0, hold: 1'b1, busy: 1'b0,
                                 done: 1'b0, err: 1'b0, rem: '0};

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    // Timeline model: m_e is the 1-based cycle index into the current train (0 = idle).
    int   m_e;
    int   m_cnt;
    int   m_per;
    int   m_hi;
    int   m_rem;
    logic m_dir;

    function automatic obs_t sample();
        obs_t o;
        o.ev   = event_o;
        o.ud   = up_down_o;
        o.hold = hold_o;
        o.busy = busy_o;
        o.done = done_o;
        o.err  = err_o;
        o.rem  = remaining_o;
        return o;
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s cyc=%0d: got ev=%b ud=%b hold=%b busy=%b done=%b err=%b rem=%0d, want ev=%b ud=%b hold=%b busy=%b done=%b err=%b rem=%0d",
                     name, cyc, act.ev, act.ud, act.hold, act.busy, act.done, act.err, act.rem,
                     exp.ev, exp.ud, exp.hold, exp.busy, exp.done, exp.err, exp.rem);
        end
    endtask

    task automatic model_reset();
        m_e   = 0;
        m_cnt = 0;
        m_per = 0;
        m_hi  = 0;
        m_rem = 0;
        m_dir = 1'b0;
    endtask

    // Advance the model by one clock edge with the given sampled inputs and queue the expected outputs.
    task automatic model_edge(input logic st, input logic ab, input logic dir,
                              input int cnt, input int per, input int hi);
        obs_t o;
        logic err;
        int   k;
        int   off;
        err = 1'b0;
        if (m_e == 0) begin
            if (st && !ab) begin
                if (cnt != 0 && per >= 2 && hi >= 1 && hi <= per - 1) begin
                    m_cnt = cnt;
                    m_per = per;
                    m_hi  = hi;
                    m_dir = dir;
                    m_e   = 1;
                end else begin
                    err = 1'b1;
                end
            end
        end else if (m_e <= m_cnt * m_per) begin
            if (ab) m_e = 0;
            else    m_e++;
        end else begin
            m_e = 0;
        end

        o      = RST_OBS;
        o.ud   = m_dir;
        o.err  = err;
        if (m_e >= 1 && m_e <= m_cnt * m_per) begin
            k      = (m_e - 1) / m_per;
            off    = (m_e - 1) % m_per;
            o.ev   = (off < m_hi);
            o.busy = 1'b1;
            o.hold = 1'b0;
            m_rem  = m_cnt - k - ((off >= m_hi) ? 1 : 0);
        end else if (m_e == m_cnt * m_per + 1) begin
            o.done = 1'b1;
            m_rem  = 0;
        end
        o.rem = CW'(m_rem);
        exp_q.push_back(o);
    endtask

    task automatic step(input logic st, input logic ab, input logic dir,
                        input int cnt, input int per, input int hi);
        @(negedge clk);
        start_i  = st;
        abort_i  = ab;
        dir_i    = dir;
        count_i  = CW'(cnt);
        period_i = PW'(per);
        high_i   = PW'(hi);
        model_edge(st, ab, dir, cnt, per, hi);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, 1'b0, 0, 0, 0);
        end
    endtask

    // Reset lands mid-cycle; outputs must drop before the next edge.
    task automatic async_reset();
        @(negedge clk);
        rst_i   = 1'b1;
        start_i = 1'b0;
        abort_i = 1'b0;
        #1;
        check("async_rst", sample(), RST_OBS);
        model_reset();
        exp_q.push_back(RST_OBS);
        @(negedge clk);
        rst_i = 1'b0;
        model_edge(1'b0, 1'b0, 1'b0, 0, 0, 0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                check("out", sample(), exp_q.pop_front());
            end
        end
    end

    initial begin
        rst_i    = 1'b1;
        start_i  = 1'b0;
        abort_i  = 1'b0;
        dir_i    = 1'b0;
        count_i  = '0;
        period_i = '0;
        high_i   = '0;
        model_reset();
        #2;
        check("reset", sample(), RST_OBS);
        @(negedge clk);
        rst_i = 1'b0;

        // rejected starts: count=0, period=1, high=0, high=period
        step(1'b1, 1'b0, 1'b1, 0, 4, 1); idle(2);
        step(1'b1, 1'b0, 1'b1, 3, 1, 1); idle(2);
        step(1'b1, 1'b0, 1'b1, 3, 4, 0); idle(2);
        step(1'b1, 1'b0, 1'b1, 3, 4, 4); idle(2);

        // basic train
        step(1'b1, 1'b0, 1'b1, 3, 4, 1); idle(16);

        // wide pulse, start ignored in DONE, then back-to-back start
        step(1'b1, 1'b0, 1'b0, 1, 5, 4); idle(5);
        step(1'b1, 1'b0, 1'b1, 2, 3, 1);
        step(1'b1, 1'b0, 1'b0, 1, 5, 4); idle(8);

        // abort while remaining=7 in a HIGH phase, then start+abort in IDLE
        step(1'b1, 1'b0, 1'b1, 10, 3, 2); idle(9);
        step(1'b0, 1'b1, 1'b0, 0, 0, 0); idle(3);
        step(1'b1, 1'b1, 1'b0, 5, 4, 1); idle(3);

        // async reset during a LOW phase, then a normal train
        step(1'b1, 1'b0, 1'b1, 5, 6, 2); idle(4);
        async_reset();
        step(1'b1, 1'b0, 1'b0, 2, 3, 1); idle(8);

        // maximum count
        step(1'b1, 1'b0, 1'b1, (1 << CW) - 1, 2, 1); idle(2 * ((1 << CW) - 1) + 2);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            int per;
            per = $urandom_range(1, 7);
            step($urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 5), per, $urandom_range(0, per));
        end
        idle(60);

        @(posedge clk);
        #3;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
